// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encoding, arbiter FSM states and the legal-op helper.
// Used by alu_share_arb (optional op check under ALU_SHARE_OPCHK_EN) and the ALU itself.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ADD  = 4'b0000,
        SUB  = 4'b0001,
        AND  = 4'b0010,
        OR   = 4'b0011,
        XOR  = 4'b0100,
        SLT  = 4'b0101,
        SLTU = 4'b0110,
        SLL  = 4'b0111,
        SRL  = 4'b1000,
        SRA  = 4'b1001
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_e;

    function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
        return op <= 4'b1001;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU; unknown op codes produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]     d0,
    input  logic [XLEN-1:0]     d1,
    input  logic [ALU_OP_W-1:0] s,
    output logic [XLEN-1:0]     y
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    // Shifts use only the low bits of operand B, so XLEN+1 wraps to a shift of 1.
    assign shamt = d1[SHW-1:0];

    always_comb begin
        y = '0;
        case (alu_op_e'(s))
            ADD:  y = d0 + d1;
            SUB:  y = d0 - d1;
            AND:  y = d0 & d1;
            OR:   y = d0 | d1;
            XOR:  y = d0 ^ d1;
            SLT:  y = {{(XLEN-1){1'b0}}, $signed(d0) < $signed(d1)};
            SLTU: y = {{(XLEN-1){1'b0}}, d0 < d1};
            SLL:  y = d0 << shamt;
            SRL:  y = d0 >> shamt;
            SRA:  y = $unsigned($signed(d0) >>> shamt);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                sum = {1'b0, ptr} + (IW+1)'(k);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                cand = sum[IW-1:0];
                if (!found && req[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    idx         = cand;
                end
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one combinational ALU among NREQ valid/ready requesters.
// Define ALU_SHARE_OPCHK_EN to flag illegal op codes via rsp_err and zero their result.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*XLEN-1:0]     req_d0,
    input  logic [NREQ*XLEN-1:0]     req_d1,
    input  logic [NREQ*ALU_OP_W-1:0] req_op,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [XLEN-1:0]          rsp_y,
    output logic                     rsp_err,
    output logic [XLEN-1:0]          alu_d0,
    output logic [XLEN-1:0]          alu_d1,
    output logic [ALU_OP_W-1:0]      alu_s,
    input  logic [XLEN-1:0]          alu_y
);

    localparam int IW = $clog2(NREQ);

    arb_state_e      state;
    arb_state_e      state_next;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gidx;
    logic            can_issue;
    logic            accept;
    logic [XLEN-1:0] y_next;
    logic            err_next;

    // A response slot frees up in the same cycle its handshake completes.
    assign can_issue = (state == IDLE) || rsp_ready[owner];

    rr_arbiter #(.N(NREQ), .IW(IW)) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .en    (can_issue),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        alu_d0 = '0;
        alu_d1 = '0;
        alu_s  = '0;
        if (accept) begin
            alu_d0 = req_d0[int'(gidx)*XLEN +: XLEN];
            alu_d1 = req_d1[int'(gidx)*XLEN +: XLEN];
            alu_s  = req_op[int'(gidx)*ALU_OP_W +: ALU_OP_W];
        end
    end

`ifdef ALU_SHARE_OPCHK_EN
    always_comb begin
        err_next = !alu_op_legal(alu_s);
        y_next   = err_next ? '0 : alu_y;
    end
`else
    always_comb begin
        err_next = 1'b0;
        y_next   = alu_y;
    end
`endif

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = RESP;
        end else if (can_issue) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            owner   <= '0;
            rsp_y   <= '0;
            rsp_err <= 1'b0;
        end else if (accept) begin
            owner   <= gidx;
            rr_ptr  <= (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
            rsp_y   <= y_next;
            rsp_err <= err_next;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[owner] = 1'b1;
        end
    end

endmodule
